rv32i_timer: RTL and testbench
==============================

RV32I_TIMER -- requirements
Module: rv32i_timer

Interface
REQ-001 SHALL have parameter CMP_RESET, default 48'hFFFF_FFFF_FFFF, reset value of mtimecmp.
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port bus_req, input, 1, register access request, single-cycle pulse.
REQ-005 SHALL have port bus_we, input, 1, 1 = write, 0 = read; sampled with bus_req.
REQ-006 SHALL have port bus_addr, input, 5, byte offset; bits [1:0] ignored.
REQ-007 SHALL have port bus_wdata, input, 32, write data.
REQ-008 SHALL have port bus_rdata, output, 32, read data, valid while bus_ready is high.
REQ-009 SHALL have port bus_ready, output, 1, response strobe.
REQ-010 SHALL have port bus_err, output, 1, unmapped-offset flag, valid with bus_ready.
REQ-011 SHALL have port mtime, output, 48, free-running time; feeds the CSR file counters.
REQ-012 SHALL have port timer_interrupt, output, 1, MTIP level to the CSR file.

Function
REQ-013 Register map SHALL be: 0x00 MTIME_LO [31:0], 0x04 MTIME_HI [47:32] in bits [15:0], 0x08 CMP_LO, 0x0C CMP_HI [15:0], 0x10 CTRL (bit0 EN, bits[15:8] DIV).
REQ-014 Any other offset SHALL return rdata 0 and err 1, and SHALL ignore writes.
REQ-015 Handshake: bus_ready SHALL pulse exactly one cycle after each bus_req, with rdata/err registered; back-to-back requests on consecutive cycles SHALL each get their own response.
REQ-016 Reads SHALL zero-extend unused bits; writes to HI registers SHALL use wdata[15:0] only.
REQ-017 Atomic read: a read of MTIME_LO SHALL latch mtime[47:32] into a 16-bit shadow in the same cycle; a subsequent MTIME_HI read SHALL return the shadow.
REQ-018 mtime SHALL increment by 1 on each tick while EN=1, wrapping 48'hFFFF_FFFF_FFFF to 0.
REQ-019 A bus write to MTIME_LO/HI SHALL take priority over a same-cycle increment; the written value SHALL appear on mtime the next cycle.
REQ-020 timer_interrupt SHALL be a register updated every cycle to (mtime >= mtimecmp) as an unsigned 48-bit comparison, giving one cycle of latency after the condition changes.
REQ-021 timer_interrupt SHALL clear one cycle after a write makes mtimecmp > mtime; it SHALL NOT be cleared by bus reads.
REQ-022 With EN=0, mtime SHALL hold, and writes to MTIME and CMP SHALL still take effect.

Reset
REQ-023 On rst: mtime=0, mtimecmp=CMP_RESET, EN=1, DIV=0, shadow=0, prescale counter=0, bus_ready=0, bus_err=0, bus_rdata=0, timer_interrupt=0.
REQ-024 rst asserted mid-transaction SHALL abort it; no response SHALL be issued for a request sampled in the reset cycle.

Configuration
REQ-025 Macro TIMER_PRESCALER_EN defined: an 8-bit prescale counter SHALL generate a tick when it equals DIV and then reset to 0 (tick period = DIV+1 cycles); it SHALL hold while EN=0 and reset to 0 on any CTRL write.
REQ-026 Macro TIMER_PRESCALER_EN undefined: a tick SHALL occur every cycle; DIV SHALL read 0 and ignore writes; no prescale counter SHALL exist.

Verification
REQ-027 Release reset, EN=1, DIV=0 -> mtime=10 ten cycles after the first clock with rst low; timer_interrupt stays 0.
REQ-028 Write CMP_LO=0x20, CMP_HI=0 -> timer_interrupt rises the cycle after mtime reaches 0x20; write CMP_LO=0x1000 -> falls the next cycle.
REQ-029 Write MTIME_HI=0xFFFF and MTIME_LO=0xFFFFFFFE -> mtime wraps to 0 two ticks later; a LO read at 0xFFFFFFFF followed by a HI read returns 0xFFFF.
REQ-030 TIMER_PRESCALER_EN with DIV=3 -> mtime advances by 1 every 4 cycles; EN=0 -> mtime frozen across 20 cycles.
REQ-031 Read at offset 0x14 -> bus_ready=1, bus_err=1, rdata=0 one cycle later; write at 0x14 -> no register changes.
REQ-032 Assert rst while timer_interrupt=1 and mid-request -> all outputs reach their reset values immediately, with no bus_ready pulse.

Source files
------------

// File: rtl/rv32i_timer.sv
// rv32i_timer: 48-bit mtime/mtimecmp machine timer with registered bus, MTIP output and optional TIMER_PRESCALER_EN prescaler
module rv32i_timer #(
  parameter logic [47:0] CMP_RESET = 48'hFFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        bus_err,
  output logic [47:0] mtime,
  output logic        timer_interrupt
);
  logic [47:0] mtimecmp;
  logic [15:0] shadow;
  logic [7:0]  div;
  logic [2:0]  idx;
  logic [31:0] rd_val;
  logic        en, tick, hit, rd, wr, unused_ok;
  assign idx       = bus_addr[4:2];
  assign hit       = idx <= 3'd4;
  assign rd        = bus_req && !bus_we;
  assign wr        = bus_req && bus_we;
  assign unused_ok = ^bus_addr[1:0];
  assign rd_val = idx == 3'd0 ? mtime[31:0] :
                  idx == 3'd1 ? {16'h0, shadow} :
                  idx == 3'd2 ? mtimecmp[31:0] :
                  idx == 3'd3 ? {16'h0, mtimecmp[47:32]} :
                  idx == 3'd4 ? {16'h0, div, 7'h0, en} : 32'h0;
`ifdef TIMER_PRESCALER_EN
  logic [7:0] presc;
  assign tick = en && presc == div;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc <= 8'h0;
      div   <= 8'h0;
    end else if (wr && idx == 3'd4) begin
      presc <= 8'h0;
      div   <= bus_wdata[15:8];
    end else if (en) begin
      presc <= tick ? 8'h0 : presc + 8'h1;
    end
`else
  assign tick = en;
  assign div  = 8'h0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mtime           <= 48'h0;
      mtimecmp        <= CMP_RESET;
      en              <= 1'b1;
      shadow          <= 16'h0;
      bus_ready       <= 1'b0;
      bus_err         <= 1'b0;
      bus_rdata       <= 32'h0;
      timer_interrupt <= 1'b0;
    end else begin
      bus_ready       <= bus_req;
      bus_err         <= bus_req && !hit;
      bus_rdata       <= rd ? rd_val : 32'h0;
      timer_interrupt <= mtime >= mtimecmp;
      if (rd && idx == 3'd0) shadow <= mtime[47:32];
      mtime <= (wr && idx == 3'd0) ? {mtime[47:32], bus_wdata} :
               (wr && idx == 3'd1) ? {bus_wdata[15:0], mtime[31:0]} :
               tick ? mtime + 48'd1 : mtime;
      mtimecmp <= (wr && idx == 3'd2) ? {mtimecmp[47:32], bus_wdata} :
                  (wr && idx == 3'd3) ? {bus_wdata[15:0], mtimecmp[31:0]} : mtimecmp;
      if (wr && idx == 3'd4) en <= bus_wdata[0];
    end
endmodule

// File: tb/tb_rv32i_timer.sv
// tb_rv32i_timer: directed self-checking bench for rv32i_timer
module tb_rv32i_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [4:0]  bus_addr = 5'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        bus_ready, bus_err, timer_interrupt;
  logic [47:0] mtime;
  int errs = 0;
  int checks = 0;
  rv32i_timer dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err),
    .mtime(mtime), .timer_interrupt(timer_interrupt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus_req = 1'b1;
    bus_we = we;
    bus_addr = a;
    bus_wdata = d;
    @(negedge clk);
    bus_req = 1'b0;
    bus_we = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_mtime", mtime, 0);
    chk("rst_irq", timer_interrupt, 0);
    chk("rst_ready", bus_ready, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_rdata", bus_rdata, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("count10", mtime, 10);
    chk("irq_low", timer_interrupt, 0);
    op(1, 5'h00, 32'h10);
    chk("wr_ready", bus_ready, 1);
    chk("wr_err", bus_err, 0);
    chk("wr_mtime_lo", mtime, 48'h10);
    op(1, 5'h08, 32'h20);
    chk("mtime_11", mtime, 48'h11);
    op(1, 5'h0C, 32'h0);
    chk("mtime_12", mtime, 48'h12);
    chk("irq_pre", timer_interrupt, 0);
    repeat (14) @(negedge clk);
    chk("reach_20", mtime, 48'h20);
    chk("irq_lat", timer_interrupt, 0);
    @(negedge clk);
    chk("irq_rise", timer_interrupt, 1);
    op(0, 5'h10, 32'h0);
    chk("rd_ctrl", bus_rdata, 32'h1);
    chk("irq_after_rd", timer_interrupt, 1);
    op(1, 5'h08, 32'h1000);
    chk("irq_hold", timer_interrupt, 1);
    @(negedge clk);
    chk("irq_fall", timer_interrupt, 0);
    op(1, 5'h04, 32'hFFFF);
    op(1, 5'h00, 32'hFFFF_FFFE);
    chk("wr_near_wrap", mtime, 48'hFFFF_FFFF_FFFE);
    @(negedge clk);
    chk("max", mtime, 48'hFFFF_FFFF_FFFF);
    op(0, 5'h00, 32'h0);
    chk("rd_lo_max", bus_rdata, 32'hFFFF_FFFF);
    chk("wrapped", mtime, 48'h0);
    op(0, 5'h04, 32'h0);
    chk("rd_hi_shadow", bus_rdata, 32'h0000_FFFF);
    op(1, 5'h10, 32'h0);
    chk("en_off", mtime, 48'h2);
    repeat (20) @(negedge clk);
    chk("frozen", mtime, 48'h2);
    op(1, 5'h00, 32'h55);
    chk("wr_while_off", mtime, 48'h55);
    @(negedge clk);
    chk("hold_55", mtime, 48'h55);
    op(1, 5'h08, 32'h60);
    op(0, 5'h08, 32'h0);
    chk("rd_cmp_lo", bus_rdata, 32'h60);
    op(0, 5'h14, 32'h0);
    chk("bad_ready", bus_ready, 1);
    chk("bad_err", bus_err, 1);
    chk("bad_rdata", bus_rdata, 0);
    op(1, 5'h14, 32'hFFFF_FFFF);
    chk("bad_wr_err", bus_err, 1);
    op(0, 5'h08, 32'h0);
    chk("cmp_kept", bus_rdata, 32'h60);
    chk("good_err", bus_err, 0);
    op(0, 5'h10, 32'h0);
    chk("ctrl_kept", bus_rdata, 32'h0);
    chk("mtime_kept", mtime, 48'h55);
    op(0, 5'h1C, 32'h0);
    chk("bad_1c_err", bus_err, 1);
    op(0, 5'h01, 32'h0);
    chk("low_bits_ign", bus_rdata, 32'h55);
    chk("low_bits_err", bus_err, 0);
    bus_req = 1'b1;
    bus_we = 1'b0;
    bus_addr = 5'h08;
    @(negedge clk);
    chk("b2b_ready0", bus_ready, 1);
    chk("b2b_rdata0", bus_rdata, 32'h60);
    bus_addr = 5'h10;
    @(negedge clk);
    chk("b2b_ready1", bus_ready, 1);
    chk("b2b_rdata1", bus_rdata, 32'h0);
    bus_req = 1'b0;
    @(negedge clk);
    chk("b2b_idle", bus_ready, 0);
    op(1, 5'h10, 32'h301);
    chk("en_on", mtime, 48'h55);
`ifdef TIMER_PRESCALER_EN
    repeat (3) @(negedge clk);
    chk("presc_hold", mtime, 48'h55);
    @(negedge clk);
    chk("presc_tick1", mtime, 48'h56);
    repeat (4) @(negedge clk);
    chk("presc_tick2", mtime, 48'h57);
    op(0, 5'h10, 32'h0);
    chk("rd_div", bus_rdata, 32'h301);
`else
    @(negedge clk);
    chk("tick_each", mtime, 48'h56);
    op(0, 5'h10, 32'h0);
    chk("rd_div0", bus_rdata, 32'h1);
`endif
    op(1, 5'h08, 32'h0);
    op(1, 5'h0C, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("irq_set", timer_interrupt, 1);
    bus_req = 1'b1;
    bus_we = 1'b0;
    bus_addr = 5'h00;
    rst = 1'b1;
    #1;
    chk("arst_mtime", mtime, 0);
    chk("arst_irq", timer_interrupt, 0);
    chk("arst_ready", bus_ready, 0);
    chk("arst_err", bus_err, 0);
    chk("arst_rdata", bus_rdata, 0);
    @(negedge clk);
    chk("arst_no_resp", bus_ready, 0);
    rst = 1'b0;
    bus_req = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus_ready, 0);
    chk("post_rst_mtime", mtime, 48'h1);
    op(0, 5'h08, 32'h0);
    chk("cmp_lo_rst", bus_rdata, 32'hFFFF_FFFF);
    op(0, 5'h0C, 32'h0);
    chk("cmp_hi_rst", bus_rdata, 32'h0000_FFFF);
    op(0, 5'h10, 32'h0);
    chk("ctrl_rst", bus_rdata, 32'h1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
